// File: rtl/sl_transmitter.sv
// sl_transmitter: serial-line word transmitter for a two-wire return-to-idle link.
// Each symbol is a low pulse on one wire (sl0 = '0', sl1 = '1'), followed by a gap
// with both wires high. A word is data bits LSB first, then an odd-parity bit, then
// a stop symbol that pulses both wires low together.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high reset
//   mode   - word length: 00=8, 01=16, 10=24, 11=32 data bits
//   data   - word to send (only the low N bits are used)
//   en     - transmit request, taken when ready is high
//   ready  - high when idle and able to accept a word
//   sl0    - line 0, idle high, low pulse = bit '0'
//   sl1    - line 1, idle high, low pulse = bit '1'
module sl_transmitter #(
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic [31:0] data,
    input  logic        en,
    output logic        ready,
    output logic        sl0,
    output logic        sl1
);

    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_t;

    state_t      state;
    logic [31:0] word;
    logic        parity;
    logic [5:0]  nbits;
    logic [5:0]  sym;
    logic [15:0] cyc;

    logic [31:0] in_mask;
    logic [5:0]  in_nbits;
    logic        in_parity;
    logic [5:0]  sym_next;

    // Line levels {sl0, sl1} for symbol index idx of an n-bit word:
    // data bits first, then parity at idx == n, then stop (both low).
    function automatic logic [1:0] sym_lines(input logic [5:0]  idx,
                                             input logic [5:0]  n,
                                             input logic [31:0] w,
                                             input logic        p);
        if (idx < n) begin
            return {w[idx[4:0]], ~w[idx[4:0]]};
        end else if (idx == n) begin
            return {p, ~p};
        end else begin
            return 2'b00;
        end
    endfunction

    always_comb begin
        in_mask = 32'hFFFF_FFFF;
        unique case (mode)
            2'b00:   in_mask = 32'h0000_00FF;
            2'b01:   in_mask = 32'h0000_FFFF;
            2'b10:   in_mask = 32'h00FF_FFFF;
            default: in_mask = 32'hFFFF_FFFF;
        endcase
        in_nbits  = {1'b0, mode, 3'b000} + 6'd8;
        // Odd parity: total count of ones including the parity bit is odd.
        in_parity = ~^(data & in_mask);
        sym_next  = sym + 6'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= StIdle;
            ready  <= 1'b1;
            sl0    <= 1'b1;
            sl1    <= 1'b1;
            word   <= '0;
            parity <= 1'b0;
            nbits  <= 6'd8;
            sym    <= '0;
            cyc    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    sl0   <= 1'b1;
                    sl1   <= 1'b1;
                    ready <= 1'b1;
                    if (en && ready) begin
                        word       <= data & in_mask;
                        parity     <= in_parity;
                        nbits      <= in_nbits;
                        sym        <= '0;
                        cyc        <= '0;
                        ready      <= 1'b0;
                        // First pulse is visible in the cycle right after accept.
                        {sl0, sl1} <= sym_lines(6'd0, in_nbits, data, in_parity);
                        state      <= StPulse;
                    end
                end
                StPulse: begin
                    if (cyc == PULSE_LAST) begin
                        cyc   <= '0;
                        sl0   <= 1'b1;
                        sl1   <= 1'b1;
                        state <= StGap;
                    end else begin
                        cyc <= cyc + 16'd1;
                    end
                end
                StGap: begin
                    if (cyc == GAP_LAST) begin
                        cyc <= '0;
                        if (sym == nbits + 6'd1) begin
                            // Stop symbol's gap done.
                            ready <= 1'b1;
                            state <= StIdle;
                        end else begin
                            sym        <= sym_next;
                            {sl0, sl1} <= sym_lines(sym_next, nbits, word, parity);
                            state      <= StPulse;
                        end
                    end else begin
                        cyc <= cyc + 16'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                    ready <= 1'b1;
                    sl0   <= 1'b1;
                    sl1   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sl_transmitter.sv
// tb_sl_transmitter: self-checking bench for sl_transmitter.
// Two instances: default timing (A) and PULSE_CYCLES=3/GAP_CYCLES=2 (B); sel picks
// which one is driven and observed. Expected symbols and ready-low lengths are queued
// when a word is issued and compared by a line monitor as pulses appear.
module tb_sl_transmitter;

    localparam int PB = 3;
    localparam int GB = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic [31:0] data = '0;
    logic        en = 1'b0;
    logic        sel = 1'b0;

    logic ready_a, sl0_a, sl1_a;
    logic ready_b, sl0_b, sl1_b;
    logic en_a, en_b;
    logic obs_rdy, obs_sl0, obs_sl1;

    assign en_a    = sel ? 1'b0 : en;
    assign en_b    = sel ? en : 1'b0;
    assign obs_rdy = sel ? ready_b : ready_a;
    assign obs_sl0 = sel ? sl0_b : sl0_a;
    assign obs_sl1 = sel ? sl1_b : sl1_a;

    sl_transmitter u_dut_a (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .data  (data),
        .en    (en_a),
        .ready (ready_a),
        .sl0   (sl0_a),
        .sl1   (sl1_a)
    );

    sl_transmitter #(
        .PULSE_CYCLES (PB),
        .GAP_CYCLES   (GB)
    ) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .mode  (mode),
        .data  (data),
        .en    (en_b),
        .ready (ready_b),
        .sl0   (sl0_b),
        .sl1   (sl1_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Symbol codes: 0 = bit '0', 1 = bit '1', 2 = stop.
    int exp_q[$];
    int rdy_q[$];

    logic rst_seen = 1'b1;
    always @(posedge clk) rst_seen <= reset;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic push_word(input logic [1:0] m, input logic [31:0] d);
        int n;
        int ones;
        n = (int'(m) + 1) * 8;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(int'(d[i]));
            ones += int'(d[i]);
        end
        exp_q.push_back((ones % 2 == 0) ? 1 : 0);
        exp_q.push_back(2);
        rdy_q.push_back((n + 2) * (sel ? (PB + GB) : 2));
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (obs_rdy) break;
        end
        check("ready_wait", int'(obs_rdy), 1);
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] d);
        wait_ready();
        #1;
        push_word(m, d);
        mode = m;
        data = d;
        en   = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        // {sl0,sl1}: bit '1' -> 2'b10, bit '0' -> 2'b01
        check("first_pulse", int'({obs_sl0, obs_sl1}), d[0] ? 2 : 1);
        check("busy_after_accept", int'(obs_rdy), 0);
    endtask

    // Line monitor / scoreboard consumer.
    initial begin : monitor
        logic [1:0] cur;
        logic [1:0] prev;
        int run;
        int sym;
        int cur_sym;
        int low_cnt;
        bit gap_chk;
        prev = 2'b11;
        run = 0;
        cur_sym = 2;
        low_cnt = 0;
        gap_chk = 1'b0;
        forever begin
            @(negedge clk);
            cur = {obs_sl0, obs_sl1};
            if (rst_seen) begin
                exp_q.delete();
                rdy_q.delete();
                prev = 2'b11;
                run = 0;
                gap_chk = 1'b0;
                low_cnt = 0;
            end else begin
                if (cur != 2'b11 && prev == 2'b11) begin
                    if (gap_chk) check("gap_len", run, sel ? GB : 1);
                    sym = (cur == 2'b01) ? 0 : (cur == 2'b10) ? 1 : 2;
                    check("pulse_expected", int'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) check("symbol", sym, exp_q.pop_front());
                    cur_sym = sym;
                    run = 1;
                end else if (cur == 2'b11 && prev != 2'b11) begin
                    check("pulse_len", run, sel ? PB : 1);
                    gap_chk = (cur_sym != 2);
                    run = 1;
                end else if (cur != prev) begin
                    check("pulse_steady", int'(cur), int'(prev));
                    run = 1;
                end else begin
                    run++;
                end
                if (!obs_rdy) begin
                    low_cnt++;
                end else if (low_cnt != 0) begin
                    check("ready_expected", int'(rdy_q.size() != 0), 1);
                    if (rdy_q.size() != 0) check("ready_low_len", low_cnt, rdy_q.pop_front());
                    low_cnt = 0;
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        // Power-on reset.
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_sl0", int'(obs_sl0), 1);
        check("reset_sl1", int'(obs_sl1), 1);
        check("reset_ready", int'(obs_rdy), 1);

        // Reset with en high: no pulse, stays idle.
        @(posedge clk);
        #1 reset = 1'b1;
        en = 1'b1;
        data = 32'h86;
        @(negedge clk);
        check("rst_en_lines", int'({obs_sl0, obs_sl1}), 3);
        check("rst_en_ready", int'(obs_rdy), 1);
        @(posedge clk);
        #1 reset = 1'b0;
        en = 1'b0;
        @(negedge clk);
        check("rst_en_after_lines", int'({obs_sl0, obs_sl1}), 3);
        check("rst_en_after_ready", int'(obs_rdy), 1);

        // 8-bit word 0x86.
        send(2'b00, 32'd134);
        // 32-bit all ones.
        send(2'b11, 32'hFFFF_FFFF);

        // en held high; data changed mid-word.
        wait_ready();
        #1;
        push_word(2'b00, 32'h86);
        mode = 2'b00;
        data = 32'h86;
        en = 1'b1;
        repeat (6) @(posedge clk);
        #1 data = 32'h01;
        push_word(2'b00, 32'h01);
        wait_ready();
        @(negedge clk);
        check("ready_one_cycle", int'(obs_rdy), 0);
        check("held_first_pulse", int'({obs_sl0, obs_sl1}), 2);
        #1 en = 1'b0;

        // Reset after three symbols, then a fresh word.
        send(2'b00, 32'hA5);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midword_reset_lines", int'({obs_sl0, obs_sl1}), 3);
        check("midword_reset_ready", int'(obs_rdy), 1);
        send(2'b00, 32'h3C);

        // Stretched timing instance.
        wait_ready();
        #1 sel = 1'b1;
        send(2'b01, 32'h0000_0001);
        wait_ready();
        @(negedge clk);
        #1;
        check("symbols_drained", exp_q.size(), 0);
        check("ready_drained", rdy_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
